// File: rtl/alu_pkg.sv
// Shared types for the ALU instruction issuer: op encoding, instruction layout, FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_ADD = 2'b01,
    ALU_SUB = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    alu_op_e    op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       use_imm;
    logic [6:0] imm;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } issuer_state_e;

endpackage

// File: rtl/alu_regfile.sv
// 4-entry register file: one synchronous write port, two combinational read ports.
module alu_regfile #(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [1:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        raddr_a_i,
  input  logic [1:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= RST_VAL;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_op_issuer.sv
// Issues decoded instructions to an external combinational ALU and writes results back.
// Optional macro ALU_ISSUE_FLAGS_EN adds registered zero/negative result flags.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                IMM_W   = 7,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  input  logic              res_ready,
`ifdef ALU_ISSUE_FLAGS_EN
  output logic              res_zero,
  output logic              res_neg,
`endif
  output logic [DATA_W-1:0] res_data,
  output logic [1:0]        res_rd
);

  issuer_state_e     state_q, state_d;
  instr_t            f;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]        alu_sel_q, alu_sel_d, rd_q, rd_d, res_rd_q, res_rd_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [DATA_W-1:0] rd_a, rd_b, opa, opb, imm_ext;
  logic              pre_we, wb, rf_we;
  logic [1:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign f       = instr_t'(instr);
  assign pre_we  = wr_en && (state_q == IDLE);
  assign wb      = (state_q == ISSUE);
  assign rf_we   = pre_we || wb;
  assign rf_waddr = wb ? rd_q : wr_addr;
  assign rf_wdata = wb ? alu_result : wr_data;

  alu_regfile #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr_a_i(f.ra),
    .raddr_b_i(f.rb),
    .rdata_a_o(rd_a),
    .rdata_b_o(rd_b)
  );

  // Operands are registered on the accept edge, so a same-cycle preload is forwarded here.
  assign imm_ext = DATA_W'(f.imm[IMM_W-1:0]);
  assign opa     = (pre_we && wr_addr == f.ra) ? wr_data : rd_a;
  assign opb     = f.use_imm ? imm_ext : ((pre_we && wr_addr == f.rb) ? wr_data : rd_b);

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    rd_d       = rd_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          alu_a_d   = opa;
          alu_b_d   = opb;
          alu_sel_d = f.op;
          rd_d      = f.rd;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        res_data_d = alu_result;
        res_rd_d   = rd_q;
        state_d    = RESP;
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      rd_q       <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      rd_q       <= rd_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  logic res_zero_q, res_neg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_zero_q <= 1'b0;
      res_neg_q  <= 1'b0;
    end else if (state_q == ISSUE) begin
      res_zero_q <= (alu_result == '0);
      res_neg_q  <= alu_result[DATA_W-1];
    end
  end

  assign res_zero = res_zero_q;
  assign res_neg  = res_neg_q;
`endif

  assign instr_ready = (state_q == IDLE);
  assign res_valid   = (state_q == RESP);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;

endmodule
